// File: rtl/uart_tx_io_pkg.sv
// Shared UART TX definitions: IO word offsets,
// STATUS bit positions, FSM states, divisor helper.
package uart_tx_io_pkg;

  localparam logic [3:0] UART_DATA   = 4'd0;
  localparam logic [3:0] UART_STATUS = 4'd1;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Truncating divide, floored at 2 so the
  // baud counter always has a real range.
  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    int d;
    d = clk_hz / baud;
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/uart_tx_io_if.sv
// IO bus bundle between CPU (master) and UART (slave).
// addr/wstrb/wdata/rstrb from master, rdata back.
interface uart_tx_io_if;
  logic [3:0]  io_addr;
  logic        io_wstrb;
  logic [31:0] io_wdata;
  logic        io_rstrb;
  logic [31:0] io_rdata;

  modport master (
    output io_addr,
    output io_wstrb,
    output io_wdata,
    output io_rstrb,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_wstrb,
    input  io_wdata,
    input  io_rstrb,
    output io_rdata
  );
endinterface

// File: rtl/uart_tx_io_sync_fifo.sv
// Synchronous FIFO, wrapping pointers, explicit count.
// Ports: push/pop, wdata_i/rdata_o, full/empty/count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == C_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + P_ONE;
      if (do_pop)  rptr_q <= rptr_q + P_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + C_ONE;
        2'b01:   count_q <= count_q - C_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO.
// Ports: clk, resetn, io (slave bus), txd (idle high).
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_io_if.slave   io,
  output logic          txd
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] B_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  tx_state_e   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        txd_q;
  logic        ovf_q;
  logic        ovf_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [CW-1:0] fifo_cnt;

  logic        wr_data;
  logic        rd_status;
  logic        baud_last;
  logic        busy;
  logic [3:0]  cnt_sat;
  logic [31:0] status_w;

  wire logic unused_wdata = &{1'b0, io.io_wdata[31:8]};

  assign wr_data   = io.io_wstrb && (io.io_addr == UART_DATA);
  assign rd_status = io.io_rstrb && (io.io_addr == UART_STATUS);
  assign fifo_push = wr_data && !fifo_full;
  assign baud_last = (baud_q == B_LAST);

  // Pop lines up with the FSM loading shift_q:
  // from IDLE, or on the final STOP cycle.
  assign fifo_pop = !fifo_empty &&
    ((state_q == S_IDLE) ||
     ((state_q == S_STOP) && baud_last));

  assign busy = (state_q != S_IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (io.io_wdata[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    cnt_sat = 4'hF;
    if (32'(fifo_cnt) < 15) cnt_sat = 4'(fifo_cnt);
  end

  always_comb begin
    status_w = '0;
    status_w[ST_BUSY]  = busy;
    status_w[ST_FULL]  = fifo_full;
    status_w[ST_EMPTY] = fifo_empty;
    status_w[ST_OVF]   = ovf_q;
    status_w[ST_CNT_LSB +: 4] = cnt_sat;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (io.io_rstrb) begin
      rdata_d = '0;
      if (io.io_addr == UART_STATUS) rdata_d = status_w;
    end
  end

  // A dropped write in the same cycle as a
  // STATUS read must not be lost: set wins.
  always_comb begin
    ovf_d = ovf_q;
    if (rd_status) ovf_d = 1'b0;
    if (wr_data && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  // txd_q follows the state one cycle late, which
  // gives the write-to-start-bit latency of 2.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            baud_q  <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          txd_q <= 1'b0;
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + B_ONE;
          end
        end
        S_DATA: begin
          txd_q <= shift_q[bit_q];
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + B_ONE;
          end
        end
        S_STOP: begin
          txd_q <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_rdata;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + B_ONE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign txd = txd_q;
  assign io.io_rdata = rdata_q;

endmodule
